// File: rtl/bitonic_pkg.sv
// Shared types and constants for the sequential bitonic sorter.
package bitonic_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Floor log2; exact for the power-of-two batch sizes used here.
  function automatic int unsigned log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n; v > 1; v = v >> 1) r++;
    return r;
  endfunction

  localparam int unsigned NUM_DEFAULT = 16;
  localparam int unsigned L = log2(NUM_DEFAULT);
  localparam int unsigned S = L * (L + 1) / 2;

endpackage

// File: rtl/Comparator.sv
// Compare-exchange cell: x/y leave in order for the requested direction.
module Comparator #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ascending,
  output logic [W-1:0] x,
  output logic [W-1:0] y
);

  logic swap;

  // Equal keys never swap.
  assign swap = ascending ? (a > b) : (a < b);
  assign x    = swap ? b : a;
  assign y    = swap ? a : b;

endmodule

// File: rtl/bitonic_cex_layer.sv
// One combinational compare-exchange layer of the bitonic network (stage k, sub-step j).
module bitonic_cex_layer
  import bitonic_pkg::*;
#(
  parameter int unsigned NUM = 16,
  parameter int unsigned W   = 16,
  parameter int unsigned KW  = 3
) (
  input  logic [NUM*W-1:0] keys_in,
  input  logic [KW-1:0]    k,
  input  logic [KW-1:0]    j,
  input  logic             direction,
  output logic [NUM*W-1:0] keys_out
);

  localparam int unsigned IW = log2(NUM);

  logic [W-1:0]  kin    [NUM];
  logic [W-1:0]  kout   [NUM];
  logic [IW-1:0] lo_idx [NUM/2];
  logic [IW-1:0] hi_idx [NUM/2];
  logic [W-1:0]  xs     [NUM/2];
  logic [W-1:0]  ys     [NUM/2];

  always_comb begin
    for (int unsigned i = 0; i < NUM; i++) kin[i] = keys_in[i*W +: W];
  end

  for (genvar c = 0; c < NUM / 2; c++) begin : g_cex
    localparam logic [IW-1:0] CI = IW'(c);
    logic [KW-1:0] jm1;
    logic [IW-1:0] d;
    logic [W-1:0]  a, b;

    // Comparator c owns lower index lo; its partner is lo+d, or the mirror
    // within the 2^k block (lo xor 2^k-1, wrapping to NUM-1 when 2^k = NUM).
    always_comb begin
      jm1       = j - KW'(1);
      d         = IW'(1) << jm1;
      lo_idx[c] = ((CI >> jm1) << j) | (CI & (d - IW'(1)));
      hi_idx[c] = (j == k) ? (lo_idx[c] ^ ((d << 1) - IW'(1))) : (lo_idx[c] | d);
    end

    assign a = kin[lo_idx[c]];
    assign b = kin[hi_idx[c]];

    Comparator #(.W(W)) u_cmp (
      .a         (a),
      .b         (b),
      .ascending (direction),
      .x         (xs[c]),
      .y         (ys[c])
    );
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM; i++) kout[i] = kin[i];
    for (int unsigned c = 0; c < NUM / 2; c++) begin
      kout[lo_idx[c]] = xs[c];
      kout[hi_idx[c]] = ys[c];
    end
    for (int unsigned i = 0; i < NUM; i++) keys_out[i*W +: W] = kout[i];
  end

endmodule

// File: rtl/bitonic_sort_seq.sv
// Sequential bitonic sorter: load NUM keys, sort one layer per cycle, drain in order.
module bitonic_sort_seq
  import bitonic_pkg::*;
#(
  parameter int unsigned NUM = 16,
  parameter int unsigned W   = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         direction,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int unsigned NL = log2(NUM);
  localparam int unsigned IW = NL;
  localparam int unsigned KW = log2(NL) + 1;

  state_t          state;
  logic [W-1:0]    key [NUM];
  logic [IW-1:0]   ld_cnt, rd_cnt;
  logic [KW-1:0]   k, j;
  logic            dir_q;
  logic [NUM*W-1:0] key_flat, layer_flat;

  always_comb begin
    for (int unsigned i = 0; i < NUM; i++) key_flat[i*W +: W] = key[i];
  end

  bitonic_cex_layer #(.NUM(NUM), .W(W), .KW(KW)) u_layer (
    .keys_in   (key_flat),
    .k         (k),
    .j         (j),
    .direction (dir_q),
    .keys_out  (layer_flat)
  );

  assign out_data = out_valid ? key[rd_cnt] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_LOAD;
      ld_cnt    <= '0;
      rd_cnt    <= '0;
      k         <= '0;
      j         <= '0;
      dir_q     <= 1'b1;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      for (int unsigned i = 0; i < NUM; i++) key[i] <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_valid) begin
            key[ld_cnt] <= in_data;
            if (ld_cnt == '0) dir_q <= direction;
            if (ld_cnt == IW'(NUM - 1)) begin
              ld_cnt   <= '0;
              k        <= KW'(1);
              j        <= KW'(1);
              in_ready <= 1'b0;
              busy     <= 1'b1;
              state    <= ST_SORT;
            end else begin
              ld_cnt <= ld_cnt + IW'(1);
            end
          end
        end
        ST_SORT: begin
          for (int unsigned i = 0; i < NUM; i++) key[i] <= layer_flat[i*W +: W];
          if (j == KW'(1)) begin
            if (k == KW'(NL)) begin
              k         <= '0;
              j         <= '0;
              out_valid <= 1'b1;
              state     <= ST_DRAIN;
            end else begin
              k <= k + KW'(1);
              j <= k + KW'(1);
            end
          end else begin
            j <= j - KW'(1);
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (rd_cnt == IW'(NUM - 1)) begin
              rd_cnt    <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              state     <= ST_LOAD;
            end else begin
              rd_cnt   <= rd_cnt + IW'(1);
              out_last <= (rd_cnt == IW'(NUM - 2));
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule
